// File: rtl/freq_counter_gen.sv
// Gated frequency counter: counts selected edges of an asynchronous input over a
// programmable window and publishes a saturating count with a one-cycle strobe.
module freq_counter_gen #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 16,
    parameter int EDGE_SEL    = 0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             IN,
    input  logic             CONT,
    input  logic             START,
    output logic [CNT_W-1:0] FREQ,
    output logic             VALID,
    output logic             OVF,
    output logic             BUSY
);

    localparam int                 TIMER_W    = $clog2(GATE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic {IDLE, GATE} state_t;

    state_t             state, state_nxt;
    logic               sync1, sync2, last;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic               sat;
    logic               rise, fall, edge_pulse;
    logic               gate_end, cnt_full;

    assign rise     = sync2 & ~last;
    assign fall     = ~sync2 & last;
    assign gate_end = (state == GATE) && (timer == TIMER_LAST);
    assign cnt_full = (edge_cnt == CNT_MAX);
    assign BUSY     = (state == GATE);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        edge_pulse = rise;
        if (EDGE_SEL == 1)
            edge_pulse = fall;
        else if (EDGE_SEL == 2)
            edge_pulse = rise | fall;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CONT || START) state_nxt = GATE;
            GATE:    if (gate_end && !CONT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RSTN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            last     <= 1'b0;
            timer    <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            FREQ     <= '0;
            VALID    <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            sync1 <= IN;
            sync2 <= sync1;
            last  <= sync2;
            VALID <= 1'b0;
            if (state == IDLE) begin
                // Edges seen while idle are dropped; the next window starts from zero.
                timer    <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (gate_end) begin
                // An edge on the final window cycle still belongs to this window.
                FREQ     <= (edge_pulse && !cnt_full) ? edge_cnt + 1'b1 : edge_cnt;
                OVF      <= sat | (edge_pulse & cnt_full);
                VALID    <= 1'b1;
                timer    <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else begin
                timer <= timer + 1'b1;
                if (edge_pulse) begin
                    if (cnt_full)
                        sat <= 1'b1;
                    else
                        edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_counter_gen.sv
// Self-checking bench for freq_counter_gen: three instances (rising, both-edge,
// narrow saturating counter) share stimulus and are compared against a sample-level model.
module tb_freq_counter_gen;

    localparam int G = 1000;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic IN = 1'b0;
    logic CONT = 1'b0;
    logic START = 1'b0;

    logic [15:0] freq_r, freq_b;
    logic [5:0]  freq_s;
    logic        valid_r, ovf_r, busy_r;
    logic        valid_b, ovf_b, busy_b;
    logic        valid_s, ovf_s, busy_s;

    int n_checks = 0;
    int n_errors = 0;
    int ph = 0;

    freq_counter_gen #(.GATE_CYCLES(G), .CNT_W(16), .EDGE_SEL(0)) dut_r (
        .CLK(CLK), .RSTN(RSTN), .IN(IN), .CONT(CONT), .START(START),
        .FREQ(freq_r), .VALID(valid_r), .OVF(ovf_r), .BUSY(busy_r));

    freq_counter_gen #(.GATE_CYCLES(G), .CNT_W(16), .EDGE_SEL(2)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .IN(IN), .CONT(CONT), .START(START),
        .FREQ(freq_b), .VALID(valid_b), .OVF(ovf_b), .BUSY(busy_b));

    freq_counter_gen #(.GATE_CYCLES(G), .CNT_W(6), .EDGE_SEL(0)) dut_s (
        .CLK(CLK), .RSTN(RSTN), .IN(IN), .CONT(CONT), .START(START),
        .FREQ(freq_s), .VALID(valid_s), .OVF(ovf_s), .BUSY(busy_s));

    always #5 CLK = ~CLK;

    // Reference model: counts transitions of the sampled input, as seen two samples late, over a window.
    int  edge_mode[3] = '{0, 2, 0};
    int  max_cnt[3]   = '{65535, 65535, 63};
    bit  m_busy, m_valid;
    int  m_timer;
    int  m_cnt[3];
    int  m_freq[3];
    bit  m_ovf[3];
    bit  seen[$];

    task automatic model_step();
        bit r, f;
        int n;
        if (!RSTN) begin
            m_busy = 1'b0;
            m_valid = 1'b0;
            m_timer = 0;
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0;
                m_freq[k] = 0;
                m_ovf[k] = 1'b0;
            end
            seen = '{1'b0, 1'b0, 1'b0};
            return;
        end
        r = seen[1] & !seen[0];
        f = !seen[1] & seen[0];
        m_valid = 1'b0;
        if (m_busy) begin
            for (int k = 0; k < 3; k++) begin
                n = (edge_mode[k] == 0) ? int'(r) : (edge_mode[k] == 1) ? int'(f) : int'(r) + int'(f);
                m_cnt[k] += n;
            end
            if (m_timer == G - 1) begin
                for (int k = 0; k < 3; k++) begin
                    m_freq[k] = (m_cnt[k] > max_cnt[k]) ? max_cnt[k] : m_cnt[k];
                    m_ovf[k] = (m_cnt[k] > max_cnt[k]);
                    m_cnt[k] = 0;
                end
                m_valid = 1'b1;
                m_timer = 0;
                m_busy = CONT;
            end else begin
                m_timer++;
            end
        end else if (CONT || START) begin
            m_busy = 1'b1;
            m_timer = 0;
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        end
        seen.push_back(IN);
        if (seen.size() > 3) void'(seen.pop_front());
    endtask

    task automatic finish_summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            if (n_errors >= 50) finish_summary();
        end
    endtask

    function automatic logic [63:0] pack(input logic b, input logic v, input logic o, input logic [31:0] f);
        return {29'd0, b, v, o, f};
    endfunction

    task automatic compare_cycle();
        check("cyc_r", pack(busy_r, valid_r, ovf_r, 32'(freq_r)), pack(m_busy, m_valid, m_ovf[0], 32'(m_freq[0])));
        check("cyc_b", pack(busy_b, valid_b, ovf_b, 32'(freq_b)), pack(m_busy, m_valid, m_ovf[1], 32'(m_freq[1])));
        check("cyc_s", pack(busy_s, valid_s, ovf_s, 32'(freq_s)), pack(m_busy, m_valid, m_ovf[2], 32'(m_freq[2])));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_cycle();
    endtask

    task automatic step(input int period);
        if (period > 0) IN = ((ph % period) < (period / 2));
        else IN = 1'b0;
        ph++;
        tick();
    endtask

    task automatic do_reset(input int period);
        RSTN = 1'b0;
        step(period);
        RSTN = 1'b1;
    endtask

    task automatic run_until_valid(input int period, input int limit, output int waited, output bit got);
        got = 1'b0;
        waited = 0;
        while (!got && waited < limit) begin
            step(period);
            waited++;
            got = valid_r;
        end
    endtask

    typedef struct {
        int period;
        int exp_r;
        int exp_b;
        int exp_s;
        bit exp_ovf_s;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   w, busy_cnt, lat, extra;
        bit   got;
        int   hold;

        vecs[0] = '{10, 100, 200, 63, 1'b1};
        vecs[1] = '{20,  50, 100, 50, 1'b0};
        vecs[2] = '{ 4, 250, 500, 63, 1'b1};
        vecs[3] = '{40,  25,  50, 25, 1'b0};
        vecs[4] = '{ 8, 125, 250, 63, 1'b1};
        vecs[5] = '{ 0,   0,   0,  0, 1'b0};

        // Reset state
        do_reset(0);
        check("rst_r", pack(busy_r, valid_r, ovf_r, 32'(freq_r)), 64'd0);
        check("rst_b", pack(busy_b, valid_b, ovf_b, 32'(freq_b)), 64'd0);
        check("rst_s", pack(busy_s, valid_s, ovf_s, 32'(freq_s)), 64'd0);

        // Continuous mode across a table of input periods
        for (int i = 0; i < 6; i++) begin
            CONT = 1'b1;
            START = 1'b0;
            do_reset(vecs[i].period);
            run_until_valid(vecs[i].period, G + 10, w, got);
            check($sformatf("row%0d_first_valid", i), 64'(got), 64'd1);
            check($sformatf("row%0d_first_latency", i), 64'(w), 64'(G + 1));
            run_until_valid(vecs[i].period, G + 10, w, got);
            check($sformatf("row%0d_valid", i), 64'(got), 64'd1);
            check($sformatf("row%0d_period", i), 64'(w), 64'(G));
            check($sformatf("row%0d_freq_r", i), 64'(freq_r), 64'(vecs[i].exp_r));
            check($sformatf("row%0d_ovf_r", i), 64'(ovf_r), 64'd0);
            check($sformatf("row%0d_freq_b", i), 64'(freq_b), 64'(vecs[i].exp_b));
            check($sformatf("row%0d_freq_s", i), 64'(freq_s), 64'(vecs[i].exp_s));
            check($sformatf("row%0d_ovf_s", i), 64'(ovf_s), 64'(vecs[i].exp_ovf_s));
        end

        // Saturation followed by a quiet window clears OVF
        CONT = 1'b1;
        do_reset(4);
        run_until_valid(4, G + 10, w, got);
        run_until_valid(4, G + 10, w, got);
        check("sat_freq", 64'(freq_s), 64'd63);
        check("sat_ovf", 64'(ovf_s), 64'd1);
        run_until_valid(0, G + 10, w, got);
        run_until_valid(0, G + 10, w, got);
        check("quiet_valid", 64'(got), 64'd1);
        check("quiet_freq", 64'(freq_s), 64'd0);
        check("quiet_ovf", 64'(ovf_s), 64'd0);

        // Single-shot with a spurious START during the window
        CONT = 1'b0;
        do_reset(20);
        repeat (30) step(20);
        START = 1'b1;
        step(20);
        START = 1'b0;
        busy_cnt = int'(busy_r);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= G + 50 && !got; i++) begin
            START = (i == 300);
            step(20);
            if (busy_r) busy_cnt++;
            if (valid_r) begin
                got = 1'b1;
                lat = i;
            end
        end
        START = 1'b0;
        check("ss_valid", 64'(got), 64'd1);
        check("ss_latency", 64'(lat), 64'(G));
        check("ss_busy_cycles", 64'(busy_cnt), 64'(G));
        check("ss_freq_r", 64'(freq_r), 64'd50);
        check("ss_freq_b", 64'(freq_b), 64'd100);
        extra = 0;
        for (int i = 0; i < 1500; i++) begin
            step(20);
            if (valid_r || busy_r) extra++;
        end
        check("ss_no_extra_gate", 64'(extra), 64'd0);
        check("ss_freq_held", 64'(freq_r), 64'd50);

        // Single rising edge landing on the final cycle of the window
        CONT = 1'b1;
        IN = 1'b0;
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        for (int j = 1; j <= G + 1; j++) begin
            IN = (j >= G - 1);
            tick();
        end
        check("edge_last_valid", 64'(valid_r), 64'd1);
        check("edge_last_freq_r", 64'(freq_r), 64'd1);
        check("edge_last_freq_b", 64'(freq_b), 64'd1);
        for (int j = 1; j <= G; j++) begin
            IN = 1'b1;
            tick();
        end
        check("edge_next_valid", 64'(valid_r), 64'd1);
        check("edge_next_freq_r", 64'(freq_r), 64'd0);

        // Reset in the middle of a window aborts it and a full window restarts
        CONT = 1'b1;
        do_reset(10);
        run_until_valid(10, G + 10, w, got);
        check("mid_pre_freq", 64'(freq_r), 64'd100);
        repeat (500) step(10);
        RSTN = 1'b0;
        step(10);
        check("mid_rst_out", pack(busy_r, valid_r, ovf_r, 32'(freq_r)), 64'd0);
        RSTN = 1'b1;
        step(10);
        check("mid_restart_busy", 64'(busy_r), 64'd1);
        run_until_valid(10, G + 10, w, got);
        check("mid_restart_len", 64'(w), 64'(G));
        check("mid_restart_freq", 64'(freq_r), 64'd100);

        // Randomized traffic against the model
        RSTN = 1'b0;
        step(0);
        RSTN = 1'b1;
        hold = 0;
        for (int i = 0; i < 12000; i++) begin
            if (hold == 0) begin
                IN = ~IN;
                hold = $urandom_range(1, 9);
            end
            hold--;
            if (i % 900 == 0) CONT = 1'($urandom_range(0, 1));
            START = ($urandom_range(0, 99) == 0);
            RSTN = !($urandom_range(0, 4999) == 0);
            tick();
        end

        finish_summary();
    end

endmodule
